// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch unit:
// loader state encoding, field ordering and address-offset arithmetic.
package imem_pkg;

    // IDLE: no program present, LOAD: accepting an image, RUN: serving fetches
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Field order inside an instruction word, least significant first
    localparam int OP_IDX = 0;
    localparam int RD_IDX = 1;
    localparam int RS_IDX = 2;
    localparam int RT_IDX = 3;
    localparam int NUM_FIELDS = 4;

    // Bit positions for the default 4-bit field width
    localparam int FIELD_W_DEF = 4;
    localparam int OP_LSB = OP_IDX * FIELD_W_DEF;
    localparam int RD_LSB = RD_IDX * FIELD_W_DEF;
    localparam int RS_LSB = RS_IDX * FIELD_W_DEF;
    localparam int RT_LSB = RT_IDX * FIELD_W_DEF;

    // LSB of field number idx for an arbitrary field width
    function automatic int field_lsb(input int idx, input int fw);
        return idx * fw;
    endfunction

    // Number of byte-offset bits in a fetch address (0 for byte-wide words)
    function automatic int byte_off_w(input int data_w);
        return (data_w <= 8) ? 0 : $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Fetch and loader signal bundle between the PC/loader side (master)
// and the instruction memory (slave).
interface imem_fetch_unit_if #(
    parameter int DATA_W  = 16,
    parameter int FIELD_W = 4,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 7
);
    // fetch port
    logic                fetch_req;
    logic [ADDR_W-1:0]   fetch_addr;
    logic                fetch_ready;
    logic                fetch_valid;
    logic                fetch_err;
    logic [DATA_W-1:0]   instruction;
    logic [FIELD_W-1:0]  op;
    logic [FIELD_W-1:0]  rd;
    logic [FIELD_W-1:0]  rs;
    logic [FIELD_W-1:0]  rt;

    // loader port
    logic                load_start;
    logic                load_valid;
    logic [DATA_W-1:0]   load_data;
    logic                load_last;
    logic                load_ready;
    logic                load_done;
    logic [CNT_W-1:0]    load_count;

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_ready, fetch_valid, fetch_err, instruction, op, rd, rs, rt,
        output load_start, load_valid, load_data, load_last,
        input  load_ready, load_done, load_count
    );

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_ready, fetch_valid, fetch_err, instruction, op, rd, rs, rt,
        input  load_start, load_valid, load_data, load_last,
        output load_ready, load_done, load_count
    );

endinterface

// File: rtl/imem_ram.sv
// 1R1W synchronous instruction RAM. A read and a write to the same address
// in one cycle return the old contents. Contents are never reset.
module imem_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port; non-blocking update gives read-before-write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a one-cycle registered fetch port, an in-system
// program loader, alignment/range error detection and op/rd/rs/rt slicing.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 64,
    parameter int FIELD_W   = 4,
    parameter int ADDR_W    = 16,
    parameter     INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_fetch_unit_if.slave bus
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = byte_off_w(DATA_W);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // A preloaded image means the unit is ready to fetch straight out of reset
    localparam bit     HAS_INIT    = (INIT_FILE != "");
    localparam state_t RESET_STATE = HAS_INIT ? RUN : IDLE;

    state_t             state_reg, state_next;
    logic [AW-1:0]      wptr_reg, wptr_next;
    logic               load_done_reg, load_done_next;
    logic [CNT_W-1:0]   load_count_reg, load_count_next;
    logic               load_wr;

    logic               fetch_valid_reg;
    logic               fetch_err_reg;
    logic [DATA_W-1:0]  instr_hold_reg;

    logic               fetch_ready;
    logic               load_ready;
    logic               accept;
    logic [ADDR_W-1:0]  word_idx;
    logic               misaligned;
    logic               out_of_range;
    logic               addr_bad;
    logic [DATA_W-1:0]  ram_rdata;
    logic [DATA_W-1:0]  instr_out;
    logic [FIELD_W-1:0] fields [NUM_FIELDS];

    // Handshake readiness: a pending load_start blocks fetch acceptance
    assign fetch_ready = (state_reg == RUN) && !bus.load_start;
    assign load_ready  = (state_reg == LOAD);
    assign accept      = bus.fetch_req && fetch_ready;

    // Address decode: byte address to word index, flag misaligned or past-the-end
    assign word_idx     = bus.fetch_addr >> OFF_W;
    assign misaligned   = (bus.fetch_addr & ADDR_W'(BYTES - 1)) != '0;
    assign out_of_range = word_idx >= ADDR_W'(DEPTH);
    assign addr_bad     = misaligned || out_of_range;

    // Loader FSM next-state: restart on load_start, finish on last word or full memory
    always_comb begin
        state_next      = state_reg;
        wptr_next       = wptr_reg;
        load_done_next  = 1'b0;
        load_count_next = load_count_reg;
        load_wr         = 1'b0;
        case (state_reg)
            IDLE, RUN: begin
                if (bus.load_start) begin
                    state_next = LOAD;
                    wptr_next  = '0;
                end
            end
            LOAD: begin
                // A restart wins over a word presented in the same cycle
                if (bus.load_start) begin
                    wptr_next = '0;
                end else if (bus.load_valid) begin
                    load_wr = 1'b1;
                    if (bus.load_last || (wptr_reg == AW'(DEPTH - 1))) begin
                        state_next      = RUN;
                        wptr_next       = '0;
                        load_done_next  = 1'b1;
                        load_count_next = CNT_W'(wptr_reg) + CNT_W'(1);
                    end else begin
                        wptr_next = wptr_reg + AW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                wptr_next  = '0;
            end
        endcase
    end

    // Loader state, write pointer and load status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RESET_STATE;
            wptr_reg       <= '0;
            load_done_reg  <= 1'b0;
            load_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            wptr_reg       <= wptr_next;
            load_done_reg  <= load_done_next;
            load_count_reg <= load_count_next;
        end
    end

    // Fetch response tracking; the held word keeps outputs stable between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
            instr_hold_reg  <= '0;
        end else begin
            fetch_valid_reg <= accept;
            if (accept) begin
                fetch_err_reg <= addr_bad;
            end
            if (fetch_valid_reg) begin
                instr_hold_reg <= instr_out;
            end
        end
    end

    // Bad addresses never touch the RAM, so its read register is left undisturbed
    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (load_wr),
        .waddr (wptr_reg),
        .wdata (bus.load_data),
        .re    (accept && !addr_bad),
        .raddr (word_idx[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign instr_out = fetch_valid_reg ? (fetch_err_reg ? '0 : ram_rdata) : instr_hold_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            assign fields[gi] = instr_out[field_lsb(gi, FIELD_W) +: FIELD_W];
        end
    endgenerate

    assign bus.fetch_ready = fetch_ready;
    assign bus.fetch_valid = fetch_valid_reg;
    assign bus.fetch_err   = fetch_err_reg;
    assign bus.instruction = instr_out;
    assign bus.op          = fields[OP_IDX];
    assign bus.rd          = fields[RD_IDX];
    assign bus.rs          = fields[RS_IDX];
    assign bus.rt          = fields[RT_IDX];
    assign bus.load_ready  = load_ready;
    assign bus.load_done   = load_done_reg;
    assign bus.load_count  = load_count_reg;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: loader scenarios, fetch errors,
// start/fetch priority, reset mid-load and a fully pipelined sweep.
module tb_imem_fetch_unit;

    localparam int DW    = 16;
    localparam int FW    = 4;
    localparam int ABW   = 16;
    localparam int DEPTH = 64;
    localparam int CW    = 7;

    typedef struct {
        logic          err;
        logic [DW-1:0] instr;
        logic [ABW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   resp_count = 0;
    int   wptr_model = 0;
    exp_t sb_q[$];
    logic [DW-1:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    imem_fetch_unit_if #(.DATA_W(DW), .FIELD_W(FW), .ADDR_W(ABW), .CNT_W(CW)) bus ();

    imem_fetch_unit #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .FIELD_W   (FW),
        .ADDR_W    (ABW),
        .INIT_FILE ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Scoreboard: every response is popped against the expectation pushed at request time
    always @(negedge clk) begin
        exp_t e;
        if (bus.fetch_valid === 1'b1) begin
            resp_count++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp got instr=%h err=%b required no response", bus.instruction, bus.fetch_err);
            end else begin
                e = sb_q.pop_front();
                if (bus.fetch_err !== e.err || bus.instruction !== e.instr ||
                    bus.op !== e.instr[3:0] || bus.rd !== e.instr[7:4] ||
                    bus.rs !== e.instr[11:8] || bus.rt !== e.instr[15:12]) begin
                    failures++;
                    $display("FAIL fetch_resp addr=%0d got err=%b instr=%h fields=%h/%h/%h/%h required err=%b instr=%h",
                             e.addr, bus.fetch_err, bus.instruction, bus.op, bus.rd, bus.rs, bus.rt, e.err, e.instr);
                end else begin
                    $display("resp addr=%0d err=%b instr=%h", e.addr, bus.fetch_err, bus.instruction);
                end
            end
        end
    end

    function automatic exp_t expect_of(input logic [ABW-1:0] addr);
        exp_t e;
        int   idx;
        idx     = int'(addr >> 1);
        e.addr  = addr;
        e.err   = addr[0] || (idx >= DEPTH);
        e.instr = e.err ? '0 : model_mem[idx];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [ABW-1:0] addr);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        sb_q.push_back(expect_of(addr));
    endtask

    task automatic begin_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        wptr_model = 0;
    endtask

    task automatic load_word(input logic [DW-1:0] data, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        model_mem[wptr_model] = data;
        wptr_model++;
        tick();
        $display("load word=%h last=%b", data, last);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic test_reset();
        bus.fetch_req = 1'b0; bus.fetch_addr = '0;
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        #1 rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.fetch_ready, bus.load_ready, bus.fetch_valid, bus.fetch_err, bus.load_done} !== 5'b0 ||
            bus.instruction !== 16'h0 || bus.load_count !== 7'd0 ||
            {bus.op, bus.rd, bus.rs, bus.rt} !== 16'h0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b lrdy=%b v=%b e=%b done=%b instr=%h cnt=%0d required all zero",
                     bus.fetch_ready, bus.load_ready, bus.fetch_valid, bus.fetch_err, bus.load_done, bus.instruction, bus.load_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_field_split();
        begin_load();
        load_word(16'h0000, 1'b0);
        load_word(16'h0000, 1'b0);
        load_word(16'h0000, 1'b0);
        load_word(16'hA5C1, 1'b1);
        tick();
        push_fetch(16'd6);
        tick();
        bus.fetch_req = 1'b0;
        checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_err !== 1'b0 ||
            {bus.rt, bus.rs, bus.rd, bus.op} !== 16'hA5C1) begin
            failures++;
            $display("FAIL field_split got v=%b e=%b rt/rs/rd/op=%h/%h/%h/%h required 1 0 A/5/C/1",
                     bus.fetch_valid, bus.fetch_err, bus.rt, bus.rs, bus.rd, bus.op);
        end
        tick();
    endtask

    task automatic test_errors();
        push_fetch(16'd7);
        tick();
        push_fetch(16'd128);
        tick();
        bus.fetch_req = 1'b0;
        checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_err !== 1'b1 || bus.instruction !== 16'h0) begin
            failures++;
            $display("FAIL range_err got v=%b e=%b instr=%h required 1 1 0000", bus.fetch_valid, bus.fetch_err, bus.instruction);
        end
        tick();
        checks++;
        if (bus.fetch_valid !== 1'b0 || bus.instruction !== 16'h0) begin
            failures++;
            $display("FAIL err_idle got v=%b instr=%h required 0 0000", bus.fetch_valid, bus.instruction);
        end
    endtask

    task automatic test_load_gap();
        begin_load();
        checks++;
        if (bus.load_ready !== 1'b1 || bus.fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_enter got lrdy=%b frdy=%b required 1 0", bus.load_ready, bus.fetch_ready);
        end
        load_word(16'h1111, 1'b0);
        tick();
        load_word(16'h2222, 1'b0);
        load_word(16'h3333, 1'b1);
        checks++;
        if (bus.load_done !== 1'b1 || bus.load_count !== 7'd3 || bus.load_ready !== 1'b0 || bus.fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL load3_done got done=%b cnt=%0d lrdy=%b frdy=%b required 1 3 0 1",
                     bus.load_done, bus.load_count, bus.load_ready, bus.fetch_ready);
        end
        tick();
        checks++;
        if (bus.load_done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got done=%b required 0", bus.load_done);
        end
        push_fetch(16'd0); tick();
        push_fetch(16'd2); tick();
        push_fetch(16'd4); tick();
        bus.fetch_req = 1'b0;
        tick();
        checks++;
        if (bus.fetch_valid !== 1'b0 || bus.instruction !== 16'h3333) begin
            failures++;
            $display("FAIL hold_last got v=%b instr=%h required 0 3333", bus.fetch_valid, bus.instruction);
        end
    endtask

    task automatic test_full_load();
        begin_load();
        for (int i = 0; i < DEPTH - 1; i++) begin
            load_word(16'h4000 + 16'(i), 1'b0);
        end
        checks++;
        if (bus.load_ready !== 1'b1 || bus.load_done !== 1'b0) begin
            failures++;
            $display("FAIL full_pre got lrdy=%b done=%b required 1 0", bus.load_ready, bus.load_done);
        end
        load_word(16'h403F, 1'b0);
        checks++;
        if (bus.load_done !== 1'b1 || bus.load_count !== 7'd64 || bus.load_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_done got done=%b cnt=%0d lrdy=%b required 1 64 0", bus.load_done, bus.load_count, bus.load_ready);
        end
        // extra word after auto-finish must be ignored
        bus.load_valid = 1'b1;
        bus.load_data  = 16'hFFFF;
        tick();
        bus.load_valid = 1'b0;
        checks++;
        if (bus.load_done !== 1'b0 || bus.load_count !== 7'd64) begin
            failures++;
            $display("FAIL extra_word got done=%b cnt=%0d required 0 64", bus.load_done, bus.load_count);
        end
        push_fetch(16'd0); tick();
        push_fetch(16'd126); tick();
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int base;
        base = resp_count;
        for (int i = 0; i < DEPTH; i++) begin
            push_fetch(16'(2 * i));
            tick();
            if (i > 0) begin
                checks++;
                if (bus.fetch_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_valid cycle=%0d got v=%b required 1", i, bus.fetch_valid);
                end
            end
        end
        bus.fetch_req = 1'b0;
        tick();
        checks++;
        if (bus.fetch_valid !== 1'b0 || resp_count - base !== 64) begin
            failures++;
            $display("FAIL b2b_count got v=%b responses=%0d required 0 64", bus.fetch_valid, resp_count - base);
        end
    endtask

    task automatic test_start_priority();
        bus.load_start = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'd0;
        #1;
        checks++;
        if (bus.fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_prio_rdy got frdy=%b required 0", bus.fetch_ready);
        end
        tick();
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b0;
        wptr_model = 0;
        checks++;
        if (bus.fetch_valid !== 1'b0 || bus.load_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_prio got v=%b lrdy=%b required 0 1", bus.fetch_valid, bus.load_ready);
        end
        load_word(16'h5A5A, 1'b0);
        load_word(16'h6B6B, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.load_ready !== 1'b0 || bus.fetch_ready !== 1'b0 || bus.load_done !== 1'b0 || bus.load_count !== 7'd0) begin
            failures++;
            $display("FAIL midload_rst got lrdy=%b frdy=%b done=%b cnt=%0d required 0 0 0 0",
                     bus.load_ready, bus.fetch_ready, bus.load_done, bus.load_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.load_done !== 1'b0 || bus.fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL post_rst got done=%b frdy=%b required 0 0", bus.load_done, bus.fetch_ready);
        end
        begin_load();
        load_word(16'h7777, 1'b1);
        checks++;
        if (bus.load_done !== 1'b1 || bus.load_count !== 7'd1) begin
            failures++;
            $display("FAIL reload got done=%b cnt=%0d required 1 1", bus.load_done, bus.load_count);
        end
        push_fetch(16'd0); tick();
        push_fetch(16'd2); tick();
        push_fetch(16'd4); tick();
        bus.fetch_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_field_split();
        test_errors();
        test_load_gap();
        test_full_load();
        test_back_to_back();
        test_start_priority();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL missing_resp got outstanding=%0d required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
